// File: rtl/ccr_pkg.sv
// Shared definitions for the condition-code register: flag bit positions,
// default width and the stack-operation decode used by ccr_nested.
package ccr_pkg;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  localparam int unsigned NFLAGS_DEF = 4;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_CONFLICT
  } stk_op_e;

  function automatic stk_op_e decode_op(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   decode_op = OP_PUSH;
      2'b01:   decode_op = OP_POP;
      2'b11:   decode_op = OP_CONFLICT;
      default: decode_op = OP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ccr_lifo.sv
// Register-array LIFO holding saved condition codes. push/pop arrive already
// qualified against full/empty, so they are never both asserted.
module ccr_lifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [LW-1:0]    level_q, level_d;

  always_comb begin
    level_d = level_q;
    mem_d   = mem_q;
    if (push) begin
      level_d = level_q + LW'(1);
    end else if (pop) begin
      level_d = level_q - LW'(1);
    end
    // Entry i is written when it is the next free slot.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (push && (level_q == LW'(i))) begin
        mem_d[i] = din;
      end
    end
  end

  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (level_q == LW'(i + 1)) begin
        top = mem_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  // Storage is not reset; entries above level are don't-care.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign level = level_q;

endmodule

// File: rtl/ccr_nested.sv
// Condition-code register with per-flag write enables, set/clear forcing,
// and a shadow stack for nested interrupt save/restore with sticky errors.
module ccr_nested
  import ccr_pkg::*;
#(
  parameter int unsigned NFLAGS = NFLAGS_DEF,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NFLAGS-1:0]            flags_in,
  input  logic [NFLAGS-1:0]            flag_en,
  input  logic [NFLAGS-1:0]            set_mask,
  input  logic [NFLAGS-1:0]            clr_mask,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         err_clr,
  output logic [NFLAGS-1:0]            ccr_reg,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty,
  output logic                         ovf_err,
  output logic                         unf_err
);

  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [NFLAGS-1:0] ccr_q, ccr_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [NFLAGS-1:0] upd, nxt, top;
  logic [LW-1:0]     lvl;
  logic              push_ok, pop_ok, push_bad, pop_bad;
  stk_op_e           op;

  assign full  = (lvl == LW'(DEPTH));
  assign empty = (lvl == '0);

  always_comb begin
    op       = decode_op(push, pop);
    push_ok  = (op == OP_PUSH) && !full;
    push_bad = (op == OP_PUSH) && full;
    pop_ok   = (op == OP_POP) && !empty;
    pop_bad  = (op == OP_POP) && empty;
  end

  // Priority: clear over set over ALU data; a valid pop overrides all of it.
  always_comb begin
    upd   = (ccr_q & ~flag_en) | (flags_in & flag_en);
    nxt   = (upd | set_mask) & ~clr_mask;
    ccr_d = pop_ok ? top : nxt;
    ovf_d = (ovf_q && !err_clr) || push_bad;
    unf_d = (unf_q && !err_clr) || pop_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ccr_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ccr_q <= ccr_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  ccr_lifo #(
    .WIDTH (NFLAGS),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop_ok),
    .din   (ccr_q),
    .top   (top),
    .level (lvl)
  );

  assign ccr_reg = ccr_q;
  assign level   = lvl;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

endmodule

// File: tb/tb_ccr_nested.sv
// Directed bench for ccr_nested (NFLAGS=4, DEPTH=2) with hand-computed expectations.
module tb_ccr_nested;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] flags_in, flag_en, set_mask, clr_mask;
  logic       push, pop, err_clr;
  logic [3:0] ccr_reg;
  logic [1:0] level;
  logic       full, empty, ovf_err, unf_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  ccr_nested #(
    .NFLAGS (4),
    .DEPTH  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flags_in (flags_in),
    .flag_en  (flag_en),
    .set_mask (set_mask),
    .clr_mask (clr_mask),
    .push     (push),
    .pop      (pop),
    .err_clr  (err_clr),
    .ccr_reg  (ccr_reg),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .ovf_err  (ovf_err),
    .unf_err  (unf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus; outputs are sampled 1ns after the edge.
  task automatic drive(input logic [3:0] fi, input logic [3:0] fe,
                       input logic [3:0] sm, input logic [3:0] cm,
                       input logic pu, input logic po, input logic ec);
    flags_in = fi; flag_en = fe; set_mask = sm; clr_mask = cm;
    push = pu; pop = po; err_clr = ec;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(4'hF, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
    drive(4'hF, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_ccr",   ccr_reg, 4'h0);
    chk("rst_level", level,   2'd0);
    chk("rst_empty", empty,   1'b1);
    chk("rst_full",  full,    1'b0);
    chk("rst_ovf",   ovf_err, 1'b0);
    chk("rst_unf",   unf_err, 1'b0);

    // 1: flag_en selective update
    drive(4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("t1_all", ccr_reg, 4'b1111);
    drive(4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("t1_c_only", ccr_reg, 4'b1011);

    // 2: clear wins over set and data, then set alone
    drive(4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("t2_zero", ccr_reg, 4'b0000);
    drive(4'b0100, 4'b1111, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
    chk("t2_clr_wins", ccr_reg, 4'b0000);
    drive(4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("t2_set", ccr_reg, 4'b0100);

    // 3: nested interrupts
    drive(4'b0101, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("t3_pre", ccr_reg, 4'b0101);
    drive(4'b0010, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("t3_push1_ccr", ccr_reg, 4'b0010);
    chk("t3_push1_lvl", level,   2'd1);
    chk("t3_push1_emp", empty,   1'b0);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("t3_push2_lvl", level, 2'd2);
    chk("t3_push2_full", full, 1'b1);
    chk("t3_push2_ccr", ccr_reg, 4'b0010);
    drive(4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("t3_pop1_ccr", ccr_reg, 4'b0010);
    chk("t3_pop1_lvl", level,   2'd1);
    chk("t3_pop1_full", full,   1'b0);
    drive(4'b0000, 4'b1111, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0);
    chk("t3_pop2_ccr", ccr_reg, 4'b0101);
    chk("t3_pop2_emp", empty,   1'b1);

    // 4: overflow, pop returns second-pushed value, err_clr
    drive(4'b0001, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("t4_p1_ccr", ccr_reg, 4'b0001);
    drive(4'b0011, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("t4_p2_lvl", level, 2'd2);
    drive(4'b1000, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("t4_ovf",     ovf_err, 1'b1);
    chk("t4_ovf_lvl", level,   2'd2);
    chk("t4_ovf_ccr", ccr_reg, 4'b1000);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("t4_pop_ccr", ccr_reg, 4'b0001);
    chk("t4_pop_lvl", level,   2'd1);
    chk("t4_ovf_sticky", ovf_err, 1'b1);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("t4_errclr", ovf_err, 1'b0);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("t4_pop2_ccr", ccr_reg, 4'b0101);
    chk("t4_pop2_emp", empty,   1'b1);

    // 5: underflow, err_clr vs new error, push+pop conflict
    drive(4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("t5_unf_ccr", ccr_reg, 4'b0001);
    chk("t5_unf",     unf_err, 1'b1);
    chk("t5_unf_lvl", level,   2'd0);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
    chk("t5_err_wins", unf_err, 1'b1);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("t5_unf_clr", unf_err, 1'b0);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("t5_push_lvl", level, 2'd1);
    drive(4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
    chk("t5_both_lvl", level,   2'd1);
    chk("t5_both_ccr", ccr_reg, 4'b1111);
    chk("t5_both_ovf", ovf_err, 1'b0);
    chk("t5_both_unf", unf_err, 1'b0);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("t5_pop_ccr", ccr_reg, 4'b0001);
    chk("t5_pop_emp", empty,   1'b1);

    // 6: reset mid-operation discards stack
    drive(4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("t6_pre_lvl", level,   2'd2);
    chk("t6_pre_ccr", ccr_reg, 4'b1111);
    rst = 1'b1;
    drive(4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    chk("t6_rst_ccr", ccr_reg, 4'b0000);
    chk("t6_rst_lvl", level,   2'd0);
    chk("t6_rst_emp", empty,   1'b1);
    chk("t6_rst_unf", unf_err, 1'b0);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("t6_unf", unf_err, 1'b1);
    chk("t6_unf_ccr", ccr_reg, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ccr_nested.md
# ccr_nested

Parametrised condition-code register with per-flag write masks, explicit set/clear controls, and a LIFO shadow stack for nested interrupt save/restore. It sits between the ALU flag outputs and the branch/control unit. Relative to the 4-flag, single-enable CCR, it adds:
- mask-selective updates, so instructions can touch only their own flags;
- SETC/CLRC-style forcing;
- hardware push on interrupt entry and pop on RTI, with overflow/underflow error reporting.

## Interface
Parameters:
- NFLAGS, 4, number of flag bits; bit order is 0=Z, 1=N, 2=C, 3=V, and higher bits are user-defined.
- DEPTH, 4, number of shadow-stack entries (≥1).

Ports (clock and reset first):
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flags_in  in  NFLAGS  new flag values from the ALU.
- flag_en  in  NFLAGS  per-bit update enable for flags_in.
- set_mask  in  NFLAGS  force selected bits to 1.
- clr_mask  in  NFLAGS  force selected bits to 0.
- push  in  1  save ccr_reg to the stack (interrupt entry).
- pop  in  1  restore ccr_reg from the stack (RTI).
- err_clr  in  1  clear the sticky error flags.
- ccr_reg  out  NFLAGS  current flags.
- level  out  $clog2(DEPTH+1)  number of occupied stack entries.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- ovf_err  out  1  sticky: a push was attempted while full.
- unf_err  out  1  sticky: a pop was attempted while empty.

## Operation
Default flag update, applied when no valid pop occurs:
- upd = (ccr_reg & ~flag_en) | (flags_in & flag_en)
- nxt = (upd | set_mask) & ~clr_mask
- clr_mask wins over set_mask, which wins over flags_in.

Valid pop (pop=1, push=0, empty=0):
- ccr_reg ← top entry; level decrements.
- flag_en, set_mask and clr_mask are ignored that cycle.

Valid push (push=1, pop=0, full=0):
- The stack stores the current (pre-update) ccr_reg; level increments.
- The default update still applies to ccr_reg in the same cycle.

Boundary and error cases:
- push=1 and pop=1 together: neither stack operation is performed, level is unchanged, the default update applies, and no error is raised.
- Push while full: entry dropped, level unchanged, ovf_err ← 1, default update applies.
- Pop while empty: ccr_reg takes the default update, unf_err ← 1.
- Errors stay set until err_clr or rst. If err_clr coincides with a new error event, the error wins and the flag is set.
- Stack contents are not read out other than on pop. Entries above level are don't-care.

## Timing
- All outputs are registered. Any input takes effect on the next rising edge of clk, so ccr_reg, level, full, empty and the error flags change one cycle after stimulus.
- No combinational path from inputs to outputs.
- Reset values: ccr_reg=0, level=0, empty=1, full=0, ovf_err=0, unf_err=0.
- Reset mid-operation discards all stacked entries; the stack memory itself need not be cleared.
- rst has priority over every other input.
- Back-to-back push/pop every cycle is supported with no bubbles. A pop in the cycle after a push returns the value pushed.
- full and empty are derived from the registered level, so they are valid in the same cycle as level.

## Structure
- Shared package ccr_pkg holds:
  - flag index constants FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3;
  - the default NFLAGS.
- Sub-module ccr_lifo (parameters WIDTH, DEPTH) implements the register-array stack:
  - inputs: push/pop strobes (already qualified by full/empty), data in;
  - outputs: top-of-stack data, level.
- ccr_nested owns the flag register, the priority/mask logic and the sticky errors.
- Expected size is about 150–250 RTL lines in total.

## Test plan
All scenarios use NFLAGS=4, DEPTH=2.
1. Reset, then flags_in=1111 with flag_en=1111 → ccr_reg=1111 one cycle later. Then flag_en=0100, flags_in=0000 → ccr_reg=1011 (only C cleared).
2. ccr_reg=0000; set_mask=0100 and clr_mask=0100 in the same cycle as flag_en=1111, flags_in=0100 → ccr_reg=0000 (clear wins). Next cycle set_mask=0100 alone → ccr_reg=0100.
3. Nested interrupts:
   - ccr_reg=0101; push with flags_in=0010, flag_en=1111 → ccr_reg=0010, level=1.
   - Push again → level=2, full=1.
   - Pop → ccr_reg=0010, level=1.
   - Pop → ccr_reg=0101, empty=1.
4. Overflow: at full (level=2), push → ovf_err=1, level=2; a later pop returns the second-pushed value. Then err_clr → ovf_err=0.
5. Underflow: empty, pop with flag_en=0001, flags_in=0001 → ccr_reg bit0=1, unf_err=1, level=0. Separately, push+pop in one cycle at level=1 → level stays 1, no error.
6. Reset mid-operation at level=2, ccr_reg=1111 → next cycle ccr_reg=0000, level=0, empty=1. A following pop sets unf_err.
